// File: rtl/pc_ctrl_pkg.sv
// Shared definitions for the PC write controller: branch-type encodings,
// exception cause codes and the controller FSM state type.
package pc_ctrl_pkg;

  localparam logic [1:0] BR_EQ = 2'b00;
  localparam logic [1:0] BR_NE = 2'b01;
  localparam logic [1:0] BR_LT = 2'b10;
  localparam logic [1:0] BR_GT = 2'b11;

  localparam logic [1:0] EXC_OPCODE   = 2'b00;
  localparam logic [1:0] EXC_OVF      = 2'b01;
  localparam logic [1:0] EXC_DIV0     = 2'b10;
  localparam logic [1:0] EXC_MISALIGN = 2'b11;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_EXC_WAIT = 1'b1
  } pc_state_e;

endpackage

// File: rtl/pc_write_ctrl_branch_cond.sv
// Branch condition evaluation (combinational).
//   br_type  in  2  branch type (BR_EQ/BR_NE/BR_LT/BR_GT)
//   alu_zero, alu_lt, alu_gt  in  ALU compare flags
//   take     out 1  branch condition is satisfied
module branch_cond
  import pc_ctrl_pkg::*;
(
  input  logic [1:0] br_type,
  input  logic       alu_zero,
  input  logic       alu_lt,
  input  logic       alu_gt,
  output logic       take
);

  always_comb begin
    take = 1'b0;
    case (br_type)
      BR_EQ:   take = alu_zero;
      BR_NE:   take = ~alu_zero;
      BR_LT:   take = alu_lt;
      BR_GT:   take = alu_gt;
      default: take = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_write_ctrl.sv
// Program counter register and write-enable controller for the multicycle
// datapath. Decides whether the PC is written, captures EPC/cause on
// exceptions and holds the PC until the handler address is loaded.
//   clk, reset_n        clock, async active-low reset
//   pc_next             next-PC value from the PC-source mux
//   pc_write            unconditional write strobe
//   pc_write_cond       conditional (branch) write strobe
//   br_type, alu_*      branch type and ALU flags
//   exc_req, exc_code   exception request and cause
//   pc, epc, exc_cause  current PC, exception PC, latched cause
//   exc_busy            waiting for the handler-address load
//   branch_taken        one-cycle pulse after a taken conditional write
//   pc_wr_count         count of accepted PC writes (wraps)
//
// state        | meaning
// ST_RUN       | normal operation, writes and exceptions accepted
// ST_EXC_WAIT  | exception captured, only pc_write (handler load) accepted
module pc_write_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EPC_OFFSET = 32'd4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] pc_next,
  input  logic        pc_write,
  input  logic        pc_write_cond,
  input  logic [1:0]  br_type,
  input  logic        alu_zero,
  input  logic        alu_lt,
  input  logic        alu_gt,
  input  logic        exc_req,
  input  logic [1:0]  exc_code,
  output logic [31:0] pc,
  output logic [31:0] epc,
  output logic [1:0]  exc_cause,
  output logic        exc_busy,
  output logic        branch_taken,
  output logic [31:0] pc_wr_count
);

  pc_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] epc_q, epc_d;
  logic [1:0]  cause_q, cause_d;
  logic        bt_q, bt_d;
  logic [31:0] cnt_q, cnt_d;
  logic        take;
  logic        wr_req;

  branch_cond u_branch_cond (
    .br_type  (br_type),
    .alu_zero (alu_zero),
    .alu_lt   (alu_lt),
    .alu_gt   (alu_gt),
    .take     (take)
  );

  assign wr_req = pc_write | (pc_write_cond & take);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      epc_q   <= '0;
      cause_q <= '0;
      bt_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
      bt_q    <= bt_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    cause_d = cause_q;
    bt_d    = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (exc_req) begin
          epc_d   = pc_q - EPC_OFFSET;
          cause_d = exc_code;
          state_d = ST_EXC_WAIT;
        end else if (wr_req && (pc_next[1:0] != 2'b00)) begin
          epc_d   = pc_q - EPC_OFFSET;
          cause_d = EXC_MISALIGN;
          state_d = ST_EXC_WAIT;
        end else if (wr_req) begin
          pc_d  = pc_next;
          cnt_d = cnt_q + 32'd1;
          // Only a write that came purely from the branch path counts as taken.
          bt_d  = ~pc_write;
        end
      end
      ST_EXC_WAIT: begin
        // Handler vector may be byte-aligned, so no alignment check here.
        if (pc_write) begin
          pc_d    = pc_next;
          cnt_d   = cnt_q + 32'd1;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign pc           = pc_q;
  assign epc          = epc_q;
  assign exc_cause    = cause_q;
  assign exc_busy     = (state_q == ST_EXC_WAIT);
  assign branch_taken = bt_q;
  assign pc_wr_count  = cnt_q;

endmodule

// File: tb/tb_pc_write_ctrl.sv
module tb_pc_write_ctrl;

  logic        clk = 1'b0;
  logic        clk_en = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] pc_next = '0;
  logic        pc_write = 1'b0;
  logic        pc_write_cond = 1'b0;
  logic [1:0]  br_type = 2'b00;
  logic        alu_zero = 1'b0;
  logic        alu_lt = 1'b0;
  logic        alu_gt = 1'b0;
  logic        exc_req = 1'b0;
  logic [1:0]  exc_code = 2'b00;
  logic [31:0] pc, epc, pc_wr_count;
  logic [1:0]  exc_cause;
  logic        exc_busy, branch_taken;

  int errors = 0;
  int checks = 0;

  pc_write_ctrl dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .pc_next       (pc_next),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .br_type       (br_type),
    .alu_zero      (alu_zero),
    .alu_lt        (alu_lt),
    .alu_gt        (alu_gt),
    .exc_req       (exc_req),
    .exc_code      (exc_code),
    .pc            (pc),
    .epc           (epc),
    .exc_cause     (exc_cause),
    .exc_busy      (exc_busy),
    .branch_taken  (branch_taken),
    .pc_wr_count   (pc_wr_count)
  );

  always #5 if (clk_en) clk = ~clk;

  // Reference model: the architectural rules of the controller.
  logic [31:0] m_pc, m_epc, m_cnt;
  logic [1:0]  m_cause;
  logic        m_in_exc, m_bt;
  logic [31:0] cnt_adj = '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_pc = 32'h0; m_epc = 32'h0; m_cnt = 32'h0;
      m_cause = 2'b00; m_in_exc = 1'b0; m_bt = 1'b0;
    end else begin
      logic cond_ok;
      logic want;
      case (br_type)
        2'b00:   cond_ok = alu_zero;
        2'b01:   cond_ok = !alu_zero;
        2'b10:   cond_ok = alu_lt;
        default: cond_ok = alu_gt;
      endcase
      want = pc_write || (pc_write_cond && cond_ok);
      m_bt = 1'b0;
      if (m_in_exc) begin
        if (pc_write) begin
          m_pc = pc_next; m_cnt = m_cnt + 1; m_in_exc = 1'b0;
        end
      end else if (exc_req) begin
        m_epc = m_pc - 32'd4; m_cause = exc_code; m_in_exc = 1'b1;
      end else if (want && (pc_next % 4 != 0)) begin
        m_epc = m_pc - 32'd4; m_cause = 2'b11; m_in_exc = 1'b1;
      end else if (want) begin
        m_pc = pc_next; m_cnt = m_cnt + 1;
        m_bt = !pc_write;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  logic cmp_on = 1'b0;
  always @(negedge clk) begin
    if (cmp_on && reset_n) begin
      chk("mdl_pc", pc, m_pc);
      chk("mdl_epc", epc, m_epc);
      chk("mdl_cause", {30'd0, exc_cause}, {30'd0, m_cause});
      chk("mdl_busy", {31'd0, exc_busy}, {31'd0, m_in_exc});
      chk("mdl_bt", {31'd0, branch_taken}, {31'd0, m_bt});
      chk("mdl_cnt", pc_wr_count, m_cnt + cnt_adj);
    end
  end

  // Drive one cycle of inputs (sampled at the next rising edge), then idle.
  task automatic cyc(input logic pw, input logic pwc, input logic [1:0] bt,
                     input logic [2:0] flags, input logic er, input logic [1:0] ec,
                     input logic [31:0] nxt);
    pc_write = pw; pc_write_cond = pwc; br_type = bt;
    {alu_zero, alu_lt, alu_gt} = flags;
    exc_req = er; exc_code = ec; pc_next = nxt;
    @(negedge clk);
    pc_write = 1'b0; pc_write_cond = 1'b0; exc_req = 1'b0;
    {alu_zero, alu_lt, alu_gt} = 3'b000;
  endtask

  initial begin
    // Reset with no clock edge at all.
    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_epc", epc, 32'h0);
    chk("rst_cause", {30'd0, exc_cause}, 32'h0);
    chk("rst_busy", {31'd0, exc_busy}, 32'h0);
    chk("rst_bt", {31'd0, branch_taken}, 32'h0);
    chk("rst_cnt", pc_wr_count, 32'h0);
    clk_en = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    cmp_on = 1'b1;

    cyc(1, 0, 2'b00, 3'b000, 0, 2'b00, 32'h4);
    chk("first_pc", pc, 32'h4);
    chk("first_cnt", pc_wr_count, 32'd1);

    cyc(1, 0, 2'b00, 3'b000, 0, 2'b00, 32'h10);
    cyc(0, 1, 2'b00, 3'b100, 0, 2'b00, 32'h40);
    chk("beq_t_pc", pc, 32'h40);
    chk("beq_t_bt", {31'd0, branch_taken}, 32'd1);
    chk("beq_t_cnt", pc_wr_count, 32'd3);
    @(negedge clk);
    chk("beq_bt_drop", {31'd0, branch_taken}, 32'd0);

    cyc(1, 0, 2'b00, 3'b000, 0, 2'b00, 32'h10);
    cyc(0, 1, 2'b00, 3'b000, 0, 2'b00, 32'h40);
    chk("beq_nt_pc", pc, 32'h10);
    chk("beq_nt_cnt", pc_wr_count, 32'd4);

    // Other branch types, taken and not taken; plus unconditional+cond together.
    cyc(0, 1, 2'b01, 3'b000, 0, 2'b00, 32'h100);
    cyc(0, 1, 2'b01, 3'b100, 0, 2'b00, 32'h108);
    cyc(0, 1, 2'b10, 3'b010, 0, 2'b00, 32'h110);
    cyc(0, 1, 2'b10, 3'b001, 0, 2'b00, 32'h118);
    cyc(0, 1, 2'b11, 3'b001, 0, 2'b00, 32'h120);
    cyc(0, 1, 2'b11, 3'b110, 0, 2'b00, 32'h128);
    cyc(1, 1, 2'b00, 3'b100, 0, 2'b00, 32'h130);
    chk("both_bt", {31'd0, branch_taken}, 32'd0);
    chk("both_pc", pc, 32'h130);

    // Overflow exception wins over a simultaneous pc_write.
    cyc(1, 0, 2'b00, 3'b000, 0, 2'b00, 32'h24);
    cyc(1, 0, 2'b00, 3'b000, 1, 2'b01, 32'h80);
    chk("ovf_epc", epc, 32'h20);
    chk("ovf_cause", {30'd0, exc_cause}, 32'd1);
    chk("ovf_pc", pc, 32'h24);
    chk("ovf_busy", {31'd0, exc_busy}, 32'd1);
    cyc(1, 0, 2'b00, 3'b000, 0, 2'b00, 32'hFE);
    chk("hdl_pc", pc, 32'hFE);
    chk("hdl_busy", {31'd0, exc_busy}, 32'd0);

    // Misaligned target.
    cyc(1, 0, 2'b00, 3'b000, 0, 2'b00, 32'h42);
    chk("mis_pc", pc, 32'hFE);
    chk("mis_cause", {30'd0, exc_cause}, 32'd3);
    chk("mis_epc", epc, 32'hFA);
    chk("mis_busy", {31'd0, exc_busy}, 32'd1);

    // No nesting: exc_req and a taken conditional write are ignored.
    cyc(0, 1, 2'b00, 3'b100, 1, 2'b10, 32'h200);
    chk("nest_cause", {30'd0, exc_cause}, 32'd3);
    chk("nest_epc", epc, 32'hFA);
    chk("nest_pc", pc, 32'hFE);

    // Asynchronous reset in the middle of the low phase.
    #2 reset_n = 1'b0;
    #1;
    chk("arst_pc", pc, 32'h0);
    chk("arst_busy", {31'd0, exc_busy}, 32'd0);
    chk("arst_epc", epc, 32'h0);
    chk("arst_cause", {30'd0, exc_cause}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Counter wrap: preload the counter to all ones.
    #2;
    force dut.cnt_q = 32'hFFFF_FFFF;
    cnt_adj = 32'hFFFF_FFFF - m_cnt;
    #1 release dut.cnt_q;
    @(negedge clk);
    cyc(1, 0, 2'b00, 3'b000, 0, 2'b00, 32'h8);
    chk("wrap_cnt", pc_wr_count, 32'h0);
    chk("wrap_pc", pc, 32'h8);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
